td4_clock_ctrl: RTL and testbench
=================================

Name: td4_clock_ctrl

Overview:
Parametrised clock controller for the TD4 CPU on the TinyFPGA BX. It replaces the fixed single-rate counter divider in the top level. It generates the CPU clock from the 16 MHz board clock with four selectable divide rates, a run/single-step mode, a debounced step button, and a one-cycle tick aligned to each CPU clock rising edge. It sits between the board clock/buttons and the cpu instance.

Parameters:
DIV0, 16000000, rate 0 period in CLK cycles (1 Hz); legal range 2..2^CNT_W-1
DIV1, 4000000, rate 1 period (4 Hz)
DIV2, 1000000, rate 2 period (16 Hz)
DIV3, 16000, rate 3 period (1 kHz)
CNT_W, 27, divider counter width
DEBOUNCE_CYCLES, 160000, consecutive stable samples needed to accept the button level (10 ms)
PULSE_CYCLES, 8000, cpu_clk high time in step mode; minimum 1
EDGE_W, 16, width of edge_count

Ports:
CLK  in  1  board clock, 16 MHz
reset  in  1  asynchronous, active-high reset
run_i  in  1  1 = free-run mode, 0 = single-step mode (asynchronous input)
rate_sel  in  2  selects DIV0..DIV3 (asynchronous input)
btn_step  in  1  raw step push-button, active-high, bouncy
cpu_clk  out  1  CPU clock, registered
cpu_tick  out  1  one-CLK pulse in the cycle cpu_clk rises, registered
running  out  1  1 while in RUN state
edge_count  out  EDGE_W  count of cpu_clk rising edges, wraps modulo 2^EDGE_W

Behaviour:
- Reset: all outputs 0; FSM in STEP_IDLE; counters 0; debounced button level 0; rate latched to 0.
- Input sync: run_i, rate_sel and btn_step each pass through a 2-flop synchroniser. Logic below uses only the synchronised versions.
- Debounce: compare the synchronised button to the accepted level each cycle.
  - Any mismatch increments the stable counter; a match clears it.
  - When the stable counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the accepted level flips and the counter clears.
  - A press event is a 0->1 flip of the accepted level.
- FSM state STEP_IDLE: cpu_clk=0.
  - A press event moves to STEP_HIGH with a rising edge on the next cycle.
  - run=1 moves to RUN with a rising edge on the next cycle.
  - If run=1 and a press event occur together, run wins and the press is dropped.
- FSM state STEP_HIGH: cpu_clk=1 for exactly PULSE_CYCLES cycles, then returns to STEP_IDLE.
  - Press events and run changes during STEP_HIGH are ignored until it exits.
  - If run=1 at exit, the next state is RUN.
- FSM state RUN: the divide counter runs 0..P-1 and wraps, where P is the latched rate.
  - cpu_clk=1 while counter < P/2 (floor); 0 otherwise.
  - rate_sel is latched into P only at the wrap (counter = P-1 -> 0), so a period is never truncated.
  - run=0 is honoured only at the wrap; the FSM then goes to STEP_IDLE with cpu_clk=0, so no runt pulses occur.
- Entry into RUN: counter=0 and cpu_clk=1 in the first RUN cycle; rate_sel is latched at entry.
- cpu_tick: high for exactly the CLK cycle in which cpu_clk first reads 1 for a new high phase. edge_count increments in the same cycle.
- Latency: press event -> cpu_clk rise takes 1 CLK. End-to-end from a stable button change: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Arithmetic: counters are unsigned and sized by CNT_W. Periods are compared against P-1 with no overflow; DIV < 2 is illegal (elaboration-time check).
- Reset mid-pulse: outputs drop to 0 immediately (asynchronously); no tick is generated on reset release.

Decomposition:
- Shared package td4_pkg holds:
  - the FSM state enum (STEP_IDLE, STEP_HIGH, RUN);
  - the 16 MHz board clock constant;
  - default DIV values.
- Sub-module td4_debounce (2-flop sync plus stable counter, parameter DEBOUNCE_CYCLES) outputs the accepted level and a press pulse. Instantiate it once, for btn_step.
- run_i and rate_sel synchronisers stay inline.

Test Plan:
(Bench parameters: DIV0=4, DIV1=6, DIV2=8, DIV3=10, DEBOUNCE_CYCLES=8, PULSE_CYCLES=3.)
- Reset then run_i=1, rate_sel=0 -> cpu_clk pattern 1100 repeating; cpu_tick every 4th cycle aligned to the rise; edge_count 1,2,3...; running=1.
- In RUN at rate 0, switch rate_sel to 1 mid-period -> the current 4-cycle period completes, then 111000 repeating; no short high or low phase.
- Step mode: btn_step bounces 0/1 for 5 cycles then holds 1 for 20 cycles -> exactly one cpu_clk high of 3 cycles and one tick; edge_count +1.
- Hold btn_step high for 7 cycles only, then release -> no cpu_clk pulse, edge_count unchanged.
- run_i 1->0 mid-high phase at rate 3 -> cpu_clk finishes the full 10-cycle period, then stays 0; running drops at the wrap.
- Assert reset during a STEP_HIGH pulse -> cpu_clk, cpu_tick, running and edge_count read 0 in the same cycle; after release, no tick until a new press event.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 clock controller: FSM states and default divide rates.
package td4_pkg;

  typedef enum logic [1:0] {
    STEP_IDLE,
    STEP_HIGH,
    RUN
  } td4_state_e;

  // TinyFPGA BX board oscillator
  localparam int unsigned BOARD_CLK_HZ = 16_000_000;

  // Default CPU clock periods in board-clock cycles: 1 Hz, 4 Hz, 16 Hz, 1 kHz
  localparam int unsigned DEF_DIV0 = BOARD_CLK_HZ;
  localparam int unsigned DEF_DIV1 = BOARD_CLK_HZ / 4;
  localparam int unsigned DEF_DIV2 = BOARD_CLK_HZ / 16;
  localparam int unsigned DEF_DIV3 = BOARD_CLK_HZ / 1000;

endpackage

// File: rtl/td4_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, accepted level and press pulse.
module td4_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 160000
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] stable_q;
  logic          level_q;
  logic          press_q;

  // Bring the raw button into the CLK domain
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Flip the accepted level after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (stable_q == STABLE_LAST) begin
          level_q  <= ~level_q;
          stable_q <= '0;
          // Only a 0->1 flip counts as a press
          press_q  <= ~level_q;
        end else begin
          stable_q <= stable_q + CW'(1);
        end
      end else begin
        stable_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/td4_clock_ctrl.sv
// TD4 CPU clock controller: four divide rates, run/single-step, debounced step button,
// rising-edge tick and edge counter. All outputs are registered.
module td4_clock_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned DIV0            = DEF_DIV0,
  parameter int unsigned DIV1            = DEF_DIV1,
  parameter int unsigned DIV2            = DEF_DIV2,
  parameter int unsigned DIV3            = DEF_DIV3,
  parameter int unsigned CNT_W           = 27,
  parameter int unsigned DEBOUNCE_CYCLES = 160000,
  parameter int unsigned PULSE_CYCLES    = 8000,
  parameter int unsigned EDGE_W          = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              run_i,
  input  logic [1:0]        rate_sel,
  input  logic              btn_step,
  output logic              cpu_clk,
  output logic              cpu_tick,
  output logic              running,
  output logic [EDGE_W-1:0] edge_count
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent
  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin : g_div_too_small
    $error("td4_clock_ctrl: every DIVn must be at least 2");
  end
  if (64'(DIV0) > CNT_MAX || 64'(DIV1) > CNT_MAX || 64'(DIV2) > CNT_MAX ||
      64'(DIV3) > CNT_MAX || 64'(PULSE_CYCLES) > CNT_MAX) begin : g_div_too_wide
    $error("td4_clock_ctrl: DIVn and PULSE_CYCLES must fit in CNT_W bits");
  end
  if (PULSE_CYCLES == 0 || DEBOUNCE_CYCLES == 0) begin : g_zero_cycles
    $error("td4_clock_ctrl: PULSE_CYCLES and DEBOUNCE_CYCLES must be at least 1");
  end

  function automatic logic [CNT_W-1:0] div_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return CNT_W'(DIV0);
      2'd1:    return CNT_W'(DIV1);
      2'd2:    return CNT_W'(DIV2);
      default: return CNT_W'(DIV3);
    endcase
  endfunction

  logic [1:0] run_sync_q;
  logic [1:0] rate_meta_q;
  logic [1:0] rate_sync_q;
  logic       run_s;
  logic       btn_level;
  logic       btn_press;
  logic       step_req;

  td4_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        rate_q;
  logic              cpu_clk_q;
  logic              cpu_tick_q;
  logic              running_q;
  logic [EDGE_W-1:0] edge_q;

  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  half;
  logic [CNT_W-1:0]  cnt_nxt;

  // Two-flop synchronisers for the mode and rate switches
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      run_sync_q  <= 2'b00;
      rate_meta_q <= 2'b00;
      rate_sync_q <= 2'b00;
    end else begin
      run_sync_q  <= {run_sync_q[0], run_i};
      rate_meta_q <= rate_sel;
      rate_sync_q <= rate_meta_q;
    end
  end

  assign run_s = run_sync_q[1];

  td4_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK    (CLK),
    .reset  (reset),
    .btn_raw(btn_step),
    .level  (btn_level),
    .press  (btn_press)
  );

  // A press is only meaningful while the accepted level is high
  assign step_req = btn_press & btn_level;

  assign period  = div_of(rate_q);
  assign half    = period >> 1;
  assign cnt_nxt = cnt_q + CNT_W'(1);

  // Clock generation FSM; cpu_tick and edge_count step only on a 0->1 of cpu_clk
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= STEP_IDLE;
      cnt_q      <= '0;
      rate_q     <= 2'd0;
      cpu_clk_q  <= 1'b0;
      cpu_tick_q <= 1'b0;
      running_q  <= 1'b0;
      edge_q     <= '0;
    end else begin
      cpu_tick_q <= 1'b0;
      case (state_q)
        STEP_IDLE: begin
          // Run has priority; a simultaneous press is dropped
          if (run_s) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            rate_q     <= rate_sync_q;
            cpu_clk_q  <= 1'b1;
            cpu_tick_q <= 1'b1;
            running_q  <= 1'b1;
            edge_q     <= edge_q + EDGE_W'(1);
          end else if (step_req) begin
            state_q    <= STEP_HIGH;
            cnt_q      <= '0;
            cpu_clk_q  <= 1'b1;
            cpu_tick_q <= 1'b1;
            edge_q     <= edge_q + EDGE_W'(1);
          end
        end
        STEP_HIGH: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_q <= '0;
            if (run_s) begin
              // cpu_clk is already high, so the first RUN high phase is not a new edge
              state_q   <= RUN;
              rate_q    <= rate_sync_q;
              running_q <= 1'b1;
            end else begin
              state_q   <= STEP_IDLE;
              cpu_clk_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        RUN: begin
          if (cnt_q == period - CNT_W'(1)) begin
            cnt_q <= '0;
            if (run_s) begin
              rate_q     <= rate_sync_q;
              cpu_clk_q  <= 1'b1;
              cpu_tick_q <= 1'b1;
              edge_q     <= edge_q + EDGE_W'(1);
            end else begin
              state_q   <= STEP_IDLE;
              cpu_clk_q <= 1'b0;
              running_q <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_nxt;
            cpu_clk_q <= (cnt_nxt < half);
          end
        end
        default: begin
          state_q   <= STEP_IDLE;
          cnt_q     <= '0;
          cpu_clk_q <= 1'b0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_clk    = cpu_clk_q;
  assign cpu_tick   = cpu_tick_q;
  assign running    = running_q;
  assign edge_count = edge_q;

endmodule

// File: tb/tb_td4_clock_ctrl.sv
// Self-checking bench for td4_clock_ctrl: directed scenarios plus randomized stimulus,
// every cycle compared against a time-based reference model.
module tb_td4_clock_ctrl;

  localparam int unsigned DIV0   = 4;
  localparam int unsigned DIV1   = 6;
  localparam int unsigned DIV2   = 8;
  localparam int unsigned DIV3   = 10;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEB    = 8;
  localparam int unsigned PULSE  = 3;
  localparam int unsigned EDGE_W = 8;

  logic              CLK = 1'b0;
  logic              reset = 1'b0;
  logic              run_i = 1'b0;
  logic [1:0]        rate_sel = 2'd0;
  logic              btn_step = 1'b0;
  logic              cpu_clk;
  logic              cpu_tick;
  logic              running;
  logic [EDGE_W-1:0] edge_count;

  td4_clock_ctrl #(
    .DIV0           (DIV0),
    .DIV1           (DIV1),
    .DIV2           (DIV2),
    .DIV3           (DIV3),
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PULSE),
    .EDGE_W         (EDGE_W)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .run_i     (run_i),
    .rate_sel  (rate_sel),
    .btn_step  (btn_step),
    .cpu_clk   (cpu_clk),
    .cpu_tick  (cpu_tick),
    .running   (running),
    .edge_count(edge_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs become visible to the controller two edges after sampling;
  // pulses and run periods are tracked by their start edge and elapsed edge count.
  bit          q_run[$];
  logic [1:0]  q_rate[$];
  bit          q_btn[$];
  int unsigned m_cyc, m_start, m_period, m_edges, m_miss;
  bit          m_in_run, m_in_pulse, m_clk, m_tick, m_lvl, m_press;

  function automatic int unsigned div_of(input logic [1:0] s);
    case (s)
      2'd0:    return DIV0;
      2'd1:    return DIV1;
      2'd2:    return DIV2;
      default: return DIV3;
    endcase
  endfunction

  task automatic model_init();
    q_run.delete(); q_rate.delete(); q_btn.delete();
    m_cyc = 0; m_start = 0; m_period = DIV0; m_edges = 0; m_miss = 0;
    m_in_run = 0; m_in_pulse = 0; m_clk = 0; m_tick = 0; m_lvl = 0; m_press = 0;
  endtask

  task automatic model_edge();
    bit          run_seen, btn_seen, prev_clk;
    logic [1:0]  rate_seen;
    q_run.push_back(run_i);
    q_rate.push_back(rate_sel);
    q_btn.push_back(btn_step);
    if (q_run.size() > 3) begin
      q_run.delete(0); q_rate.delete(0); q_btn.delete(0);
    end
    run_seen  = (q_run.size() == 3) ? q_run[0] : 1'b0;
    rate_seen = (q_rate.size() == 3) ? q_rate[0] : 2'd0;
    btn_seen  = (q_btn.size() == 3) ? q_btn[0] : 1'b0;
    m_cyc++;
    prev_clk = m_clk;
    if (m_in_pulse) begin
      if (m_cyc - m_start == PULSE) begin
        m_in_pulse = 0;
        if (run_seen) begin
          m_in_run = 1; m_start = m_cyc; m_period = div_of(rate_seen);
        end
      end
    end else if (m_in_run) begin
      if (m_cyc - m_start == m_period) begin
        if (run_seen) begin
          m_start = m_cyc; m_period = div_of(rate_seen);
        end else begin
          m_in_run = 0;
        end
      end
    end else begin
      if (run_seen) begin
        m_in_run = 1; m_start = m_cyc; m_period = div_of(rate_seen);
      end else if (m_press) begin
        m_in_pulse = 1; m_start = m_cyc;
      end
    end
    m_clk  = m_in_pulse || (m_in_run && (m_cyc - m_start) < m_period / 2);
    m_tick = m_clk && !prev_clk;
    if (m_tick) m_edges++;
    // Button: accept a new level after DEB consecutive disagreeing samples
    m_press = 0;
    if (btn_seen != m_lvl) begin
      m_miss++;
      if (m_miss == DEB) begin
        m_lvl   = !m_lvl;
        m_miss  = 0;
        m_press = m_lvl;
      end
    end else begin
      m_miss = 0;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    model_edge();
    check_eq("cpu_clk", cpu_clk, m_clk);
    check_eq("cpu_tick", cpu_tick, m_tick);
    check_eq("running", running, m_in_run);
    check_eq("edge_count", edge_count, m_edges % (1 << EDGE_W));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_cpu_clk", cpu_clk, 0);
    check_eq("rst_cpu_tick", cpu_tick, 0);
    check_eq("rst_running", running, 0);
    check_eq("rst_edge_count", edge_count, 0);
    model_init();
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output bit found);
    found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      cycle();
      if (cpu_tick) found = 1;
    end
  endtask

  // Bit k holds the sample k cycles after the current one (bit 0 = now)
  task automatic capture(input int n, input int drop_run_at,
                         output logic [15:0] clk_bits, output logic [15:0] tick_bits,
                         output logic [15:0] run_bits);
    clk_bits = '0; tick_bits = '0; run_bits = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) cycle();
      clk_bits[k]  = cpu_clk;
      tick_bits[k] = cpu_tick;
      run_bits[k]  = running;
      if (k == drop_run_at) run_i = 1'b0;
    end
  endtask

  task automatic count_window(input int n, output int highs, output int ticks);
    highs = 0; ticks = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (cpu_clk) highs++;
      if (cpu_tick) ticks++;
    end
  endtask

  initial begin
    bit          found;
    logic [15:0] cb, tb_, rb;
    int          highs, ticks, hold;
    int unsigned e_base;

    #2;
    do_reset();

    // Free run at rate 0: 1100 pattern
    run_i = 1'b1; rate_sel = 2'd0;
    wait_tick(12, found);
    check_eq("run_entry_tick", found, 1);
    capture(8, -1, cb, tb_, rb);
    check_eq("rate0_clk_pattern", cb, 16'h0033);
    check_eq("rate0_tick_pattern", tb_, 16'h0011);
    check_eq("rate0_running", rb, 16'h00FF);

    // Rate change mid-period: current 4-cycle period completes, then 111000
    wait_tick(8, found);
    check_eq("rate_sw_tick", found, 1);
    rate_sel = 2'd1;
    capture(16, -1, cb, tb_, rb);
    check_eq("rate_sw_clk_pattern", cb, 16'h1C73);
    check_eq("rate_sw_tick_pattern", tb_, 16'h0411);

    // Leave run mode
    run_i = 1'b0;
    repeat (20) cycle();
    check_eq("run_stopped", running, 0);

    // Bouncy press then steady hold: exactly one 3-cycle pulse
    e_base = m_edges;
    highs = 0; ticks = 0;
    for (int i = 0; i < 5; i++) begin
      btn_step = (i % 2 == 0);
      cycle();
      if (cpu_clk) highs++;
      if (cpu_tick) ticks++;
    end
    btn_step = 1'b1;
    begin
      int h, t;
      count_window(20, h, t);
      highs += h; ticks += t;
      btn_step = 1'b0;
      count_window(15, h, t);
      highs += h; ticks += t;
    end
    check_eq("step_high_cycles", highs, PULSE);
    check_eq("step_ticks", ticks, 1);
    check_eq("step_edges", edge_count, (e_base + 1) % (1 << EDGE_W));

    // Press too short to be accepted
    e_base = m_edges;
    btn_step = 1'b1;
    count_window(7, highs, ticks);
    btn_step = 1'b0;
    begin
      int h, t;
      count_window(20, h, t);
      highs += h; ticks += t;
    end
    check_eq("short_press_high", highs, 0);
    check_eq("short_press_ticks", ticks, 0);
    check_eq("short_press_edges", edge_count, e_base % (1 << EDGE_W));

    // Stop request mid-high at rate 3: full 10-cycle period, then low
    rate_sel = 2'd3; run_i = 1'b1;
    wait_tick(12, found);
    check_eq("rate3_entry_tick", found, 1);
    capture(16, 2, cb, tb_, rb);
    check_eq("rate3_stop_clk", cb, 16'h001F);
    check_eq("rate3_stop_running", rb, 16'h03FF);
    check_eq("rate3_stop_ticks", tb_, 16'h0001);

    // Reset in the middle of a step pulse
    btn_step = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (cpu_clk) found = 1;
    end
    check_eq("pulse_before_reset", found, 1);
    cycle();
    btn_step = 1'b0;
    do_reset();
    count_window(30, highs, ticks);
    check_eq("post_reset_ticks", ticks, 0);
    check_eq("post_reset_edges", edge_count, 0);

    // Randomized stimulus against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run_i = ~run_i;
      if ($urandom_range(0, 7) == 0) rate_sel = 2'($urandom_range(0, 3));
      if (hold == 0) begin
        btn_step = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 16);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
